ternary_regfile: RTL
====================

Name: ternary_regfile

Overview:
- Balanced-ternary general-purpose register file directly upstream of the 8-trit ALU.
- Its two read ports drive the ALU `a` and `b` operand buses.
- Its write port takes the ALU `result` (or load data) at writeback.
- Each trit is 2 bits, encoded with the `T_NEG_ONE` / `T_ZERO` / `T_POS_ONE` / `T_INVALID` macros from ternary_defs.vh.
- The block guarantees that `T_INVALID` trits never enter architectural state.

Parameters:
- WIDTH, 8, trits per register; data buses are WIDTH*2 bits.
- NUM_REGS, 9, number of architectural registers R0..R(NUM_REGS-1); R0 is hardwired to zero.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= NUM_REGS.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- raddr_a  input  ADDR_W  read port A address.
- rdata_a  output  WIDTH*2  read port A data, combinational; feeds ALU `a`.
- raddr_b  input  ADDR_W  read port B address.
- rdata_b  output  WIDTH*2  read port B data, combinational; feeds ALU `b`.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address.
- wdata  input  WIDTH*2  write data; normally the ALU result.
- wr_err  output  1  registered error pulse for a rejected write.
- err_cnt  output  8  saturating count of rejected writes.

Behaviour:
- Reset: asynchronous and active-low, as already decided.
  - While rst_n is low, every register R1..R(NUM_REGS-1) has each trit set to `T_ZERO`.
  - wr_err = 0 and err_cnt = 0 during reset.
  - Reset asserted mid-write wins: the pending write is lost.
- Read path is purely combinational; data is valid the same cycle as the address.
  - Address 0 returns all trits `T_ZERO`.
  - Address >= NUM_REGS returns all trits `T_ZERO`.
- Write, on the rising clk edge with we = 1:
  - The write commits only if waddr is in 1..NUM_REGS-1 and no trit of wdata equals `T_INVALID`.
  - A committed write is visible on the read ports the next cycle (subject to the optional feature).
  - waddr = 0 with we = 1: silently ignored, no error.
  - Rejected write: waddr >= NUM_REGS, or any wdata trit is `T_INVALID`.
    - Target register is unchanged.
    - wr_err = 1 for exactly the following cycle.
    - err_cnt increments, saturating at 255.
  - Back-to-back rejected writes hold wr_err high for consecutive cycles.
  - we = 0: wr_err = 0 the next cycle, and all state is held.
- Simultaneous events:
  - Both read ports may address the same register, and/or the write target, in the same cycle.
  - Reads never block writes. There is no structural hazard.
- err_cnt clears only on reset.

Optional Feature:
- Macro: TERNARY_RF_BYPASS_EN.
- Defined: write-through bypass.
  - Applies when we = 1, the write is committable (valid address 1..NUM_REGS-1, no invalid trit), and raddr_x == waddr.
  - In that case rdata_x returns wdata in the same cycle.
  - Rejected writes and R0 writes are never bypassed.
  - This lets a dependent ALU op issue the cycle after its producer with no stall.
- Not defined: no bypass; reads always return the pre-edge stored value.

Test Plan:
- Reset value: assert rst_n = 0 mid-run, then release. Required: rdata_a / rdata_b read all `T_ZERO` for every address; wr_err = 0; err_cnt = 0.
- Basic write/read: write R3 = trits {+1,0,-1,0,+1,+1,-1,0}. Required: the next cycle, raddr_a = 3 returns exactly that data and raddr_b = 3 matches.
- R0 hardwire: we = 1, waddr = 0, wdata = all `T_POS_ONE`. Required: R0 still reads all `T_ZERO` and wr_err stays 0.
- Invalid trit rejected: write R5 with trit 2 = `T_INVALID`. Required: R5 unchanged; wr_err = 1 for one cycle; err_cnt goes 0 -> 1.
- Out-of-range address: two consecutive writes to waddr = 12. Required: wr_err high for 2 cycles; err_cnt = 2; a read of address 12 returns all `T_ZERO`. Also drive 300 rejected writes. Required: err_cnt saturates at 255.
- Bypass: write R4 = all `T_NEG_ONE` while raddr_a = 4 in the same cycle.
  - With TERNARY_RF_BYPASS_EN defined: rdata_a = all `T_NEG_ONE` in that same cycle.
  - Without the macro: rdata_a shows the old value in that cycle and the new value the next cycle.

Source files
------------

// File: rtl/ternary_regfile_if.sv
// Operand/writeback bus between the ternary register file and the 8-trit ALU.
// Two combinational read ports, one write port and the rejected-write status.
interface ternary_regfile_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0]  raddr_a;
  logic [WIDTH*2-1:0] rdata_a;
  logic [ADDR_W-1:0]  raddr_b;
  logic [WIDTH*2-1:0] rdata_b;
  logic               we;
  logic [ADDR_W-1:0]  waddr;
  logic [WIDTH*2-1:0] wdata;
  logic               wr_err;
  logic [7:0]         err_cnt;

  modport master (
    output raddr_a, raddr_b, we, waddr, wdata,
    input  rdata_a, rdata_b, wr_err, err_cnt
  );

  modport slave (
    input  raddr_a, raddr_b, we, waddr, wdata,
    output rdata_a, rdata_b, wr_err, err_cnt
  );
endinterface

// File: rtl/ternary_regfile.sv
// Balanced-ternary register file feeding the ALU; R0 reads zero, invalid trits never stored.
// Optional macro TERNARY_RF_BYPASS_EN adds same-cycle write-through to the read ports.
module ternary_regfile #(
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 9,
  parameter int ADDR_W   = 4
) (
  input logic               clk,
  input logic               rst_n,
  ternary_regfile_if.slave  bus
);

  localparam logic [1:0] T_ZERO    = 2'b00;
  localparam logic [1:0] T_POS_ONE = 2'b01;
  localparam logic [1:0] T_NEG_ONE = 2'b10;
  localparam logic [1:0] T_INVALID = 2'b11;

  localparam logic [WIDTH*2-1:0] ZERO_WORD = {WIDTH{T_ZERO}};
  localparam logic [ADDR_W:0]    NREGS     = NUM_REGS[ADDR_W:0];

  logic [WIDTH*2-1:0] regs [0:NUM_REGS-1];
  logic               wr_err;
  logic [7:0]         err_cnt;
  logic               waddr_ok;
  logic               wdata_bad;
  logic               commit;
  logic               reject;
  logic [WIDTH*2-1:0] rdata_a;
  logic [WIDTH*2-1:0] rdata_b;

  function automatic logic has_invalid(input logic [WIDTH*2-1:0] d);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (d[2*i +: 2] == T_INVALID) bad = 1'b1;
    end
    return bad;
  endfunction

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS);
  endfunction

  // Writes to R0 are dropped quietly even if the data also carries invalid trits.
  always_comb begin
    waddr_ok  = (bus.waddr != '0) && in_range(bus.waddr);
    wdata_bad = has_invalid(bus.wdata);
    commit    = bus.we && waddr_ok && !wdata_bad;
    reject    = bus.we && (bus.waddr != '0) && (!in_range(bus.waddr) || wdata_bad);
  end

  always_comb begin
    rdata_a = ZERO_WORD;
    if (bus.raddr_a != '0 && in_range(bus.raddr_a)) rdata_a = regs[bus.raddr_a];
`ifdef TERNARY_RF_BYPASS_EN
    if (commit && bus.raddr_a == bus.waddr) rdata_a = bus.wdata;
`endif
  end

  always_comb begin
    rdata_b = ZERO_WORD;
    if (bus.raddr_b != '0 && in_range(bus.raddr_b)) rdata_b = regs[bus.raddr_b];
`ifdef TERNARY_RF_BYPASS_EN
    if (commit && bus.raddr_b == bus.waddr) rdata_b = bus.wdata;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= ZERO_WORD;
    end else if (commit) begin
      regs[bus.waddr] <= bus.wdata;
    end
  end

  // wr_err is a one-cycle echo of this cycle's rejection; the counter sticks at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err  <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      wr_err <= reject;
      if (reject && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.rdata_a = rdata_a;
  assign bus.rdata_b = rdata_b;
  assign bus.wr_err  = wr_err;
  assign bus.err_cnt = err_cnt;

  logic unused_enc;
  assign unused_enc = ^{T_POS_ONE, T_NEG_ONE};

endmodule
